id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage pipeline, with integrated load-use hazard detection.
- Captures decoded control, register operands and register numbers each cycle.
- Presents ID_Ex_Rs/ID_Ex_Rt/ID_Ex_RegWr and related fields to the forwarding unit and EX stage.
- Stalls PC and IF/ID and inserts bubbles when an EX-stage load feeds the instruction in ID; clears to a bubble on branch flush.

Parameters:
DATA_W, 32, width of busA/busB/imm datapath
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..3; >1 for slow data memory)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
IF_ID_Rs  in  5  rs field of instruction in ID
IF_ID_Rt  in  5  rt field of instruction in ID
IF_ID_Rd  in  5  rd field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source (R-type, sw, beq)
id_RegWr, id_MemRead, id_MemWr, id_MemtoReg, id_RegDst, id_ALUsrc  in  1 each  decoded control
id_ALUctr  in  4  decoded ALU operation
id_busA, id_busB, id_imm  in  DATA_W each  register-file reads, extended immediate
flush  in  1  branch/jump taken: squash instruction in ID
ID_Ex_Rs, ID_Ex_Rt, ID_Ex_Rd  out  5 each  registered register numbers
ID_Ex_RegWr, ID_Ex_MemRead, ID_Ex_MemWr, ID_Ex_MemtoReg, ID_Ex_RegDst, ID_Ex_ALUsrc  out  1 each  registered control
ID_Ex_ALUctr  out  4  registered ALU operation
ID_Ex_busA, ID_Ex_busB, ID_Ex_imm  out  DATA_W each  registered operands
PC_Wr  out  1  PC write enable (0 = hold)
IF_ID_Wr  out  1  IF/ID write enable (0 = hold)
stall_active  out  1  high in every cycle a bubble is being inserted due to hazard

Behaviour:
- Reset (rst_n=0, async): all ID_Ex_* outputs 0 (a bubble); FSM to RUN; stall counter 0.
  - Outputs while in reset: PC_Wr=1, IF_ID_Wr=1, stall_active=0.
- Hazard detect (combinational, state RUN): haz = ID_Ex_MemRead & (ID_Ex_Rt!=0) & ((ID_Ex_Rt==IF_ID_Rs) | (id_uses_rt & (ID_Ex_Rt==IF_ID_Rt))).
- FSM states: RUN, STALL.
  - RUN, haz=0, flush=0:
    - Next clock latches all id_* into ID_Ex_* (latency 1 cycle).
    - PC_Wr=1, IF_ID_Wr=1, stall_active=0.
  - RUN, haz=1, flush=0:
    - PC_Wr=0, IF_ID_Wr=0, stall_active=1.
    - Next clock loads a bubble: all control outputs and ID_Ex_Rs/Rt/Rd = 0; busA/busB/imm may hold any value.
    - If LOAD_STALL_CYCLES=1, stay in RUN. Otherwise go to STALL with counter = LOAD_STALL_CYCLES-1.
  - STALL:
    - PC_Wr=0, IF_ID_Wr=0, stall_active=1; a bubble is loaded each clock; counter decrements.
    - When counter reaches 1 and is consumed, return to RUN; the held ID instruction then latches on the following edge.
    - haz is not re-evaluated in STALL, because the register already holds a bubble.
- flush=1 (any state) has priority over hazard:
  - Next clock loads a bubble; FSM to RUN; counter cleared.
  - PC_Wr=1, IF_ID_Wr=1, stall_active=0 in that cycle.
- Bubble total per hazard = LOAD_STALL_CYCLES exactly. The instruction in ID enters EX LOAD_STALL_CYCLES+1 edges after hazard detection.
- Bubble fields are all zero, so the forwarding unit sees RegWr=0 and Rd=0 and does not forward from a bubble.
- No write enable gates the register other than hazard/flush; it updates every clock.
- Reset mid-stall clears immediately (async). First post-reset cycle is RUN with a bubble in EX.

Test Plan:
- Reset then pass-through: release rst_n; drive id_RegWr=1, IF_ID_Rs=3, id_busA=0x12345678 -> after 1 edge ID_Ex_RegWr=1, ID_Ex_Rs=3, ID_Ex_busA=0x12345678; PC_Wr=IF_ID_Wr=1 throughout.
- Load-use on rs: lw into $8 (ID_Ex_MemRead=1, ID_Ex_Rt=8), then ID holds add with IF_ID_Rs=8 -> PC_Wr=0, IF_ID_Wr=0, stall_active=1 for 1 cycle; next edge all ID_Ex control=0; the edge after that latches the add.
- Rt cases:
  - ID_Ex_Rt=0 with MemRead=1 and IF_ID_Rs=0 -> no stall.
  - ID_Ex_Rt=9, IF_ID_Rt=9, id_uses_rt=0 (addi) -> no stall.
  - Same with id_uses_rt=1 -> 1-cycle stall.
- LOAD_STALL_CYCLES=3, hazard on rs -> stall_active high exactly 3 consecutive cycles; 3 bubbles enter EX; the held instruction enters on the 4th edge.
- Flush during STALL (LOAD_STALL_CYCLES=3, flush asserted in 2nd stall cycle) -> that cycle PC_Wr=1, stall_active=0; bubble loaded; FSM RUN; no further stall cycles.
- Reset mid-stall: pull rst_n low in 2nd stall cycle -> all ID_Ex_* 0 immediately (no clock edge); PC_Wr=1; after release, normal pass-through resumes on the next edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Stalls PC and IF/ID and injects bubbles for EX-stage loads, and squashes the ID instruction on flush.
module id_ex_stage #(
    parameter int unsigned DATA_W            = 32,
    parameter int unsigned LOAD_STALL_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        IF_ID_Rs,
    input  logic [4:0]        IF_ID_Rt,
    input  logic [4:0]        IF_ID_Rd,
    input  logic              id_uses_rt,
    input  logic              id_RegWr,
    input  logic              id_MemRead,
    input  logic              id_MemWr,
    input  logic              id_MemtoReg,
    input  logic              id_RegDst,
    input  logic              id_ALUsrc,
    input  logic [3:0]        id_ALUctr,
    input  logic [DATA_W-1:0] id_busA,
    input  logic [DATA_W-1:0] id_busB,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              flush,
    output logic [4:0]        ID_Ex_Rs,
    output logic [4:0]        ID_Ex_Rt,
    output logic [4:0]        ID_Ex_Rd,
    output logic              ID_Ex_RegWr,
    output logic              ID_Ex_MemRead,
    output logic              ID_Ex_MemWr,
    output logic              ID_Ex_MemtoReg,
    output logic              ID_Ex_RegDst,
    output logic              ID_Ex_ALUsrc,
    output logic [3:0]        ID_Ex_ALUctr,
    output logic [DATA_W-1:0] ID_Ex_busA,
    output logic [DATA_W-1:0] ID_Ex_busB,
    output logic [DATA_W-1:0] ID_Ex_imm,
    output logic              PC_Wr,
    output logic              IF_ID_Wr,
    output logic              stall_active
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    // Control and register-number fields that a bubble forces to zero
    typedef struct packed {
        logic       reg_wr;
        logic       mem_read;
        logic       mem_wr;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src;
        logic [3:0] alu_ctr;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } ctrl_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              haz_c;
    logic              bubble_c;
    ctrl_t             ctrl_q;
    ctrl_t             ctrl_d;
    logic [DATA_W-1:0] bus_a_q;
    logic [DATA_W-1:0] bus_b_q;
    logic [DATA_W-1:0] imm_q;

    // Load in EX whose destination is a source of the instruction in ID
    assign haz_c = ctrl_q.mem_read && (ctrl_q.rt != 5'd0) &&
                   ((ctrl_q.rt == IF_ID_Rs) || (id_uses_rt && (ctrl_q.rt == IF_ID_Rt)));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; flush overrides any pending stall
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bubble_c  = 1'b0;
        if (flush) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
            bubble_c  = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (haz_c) begin
                        bubble_c = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_nxt = STALL;
                            cnt_nxt   = CNT_W'(LOAD_STALL_CYCLES - 1);
                        end
                    end
                end
                STALL: begin
                    bubble_c = 1'b1;
                    if (cnt <= CNT_W'(1)) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Stall outputs: hold PC and IF/ID while a hazard bubble is being inserted
    always_comb begin
        stall_active = 1'b0;
        if (!flush) begin
            case (state)
                RUN:     stall_active = haz_c;
                STALL:   stall_active = 1'b1;
                default: stall_active = 1'b0;
            endcase
        end
        PC_Wr    = !stall_active;
        IF_ID_Wr = !stall_active;
    end

    always_comb begin
        ctrl_d = '{
            reg_wr:     id_RegWr,
            mem_read:   id_MemRead,
            mem_wr:     id_MemWr,
            mem_to_reg: id_MemtoReg,
            reg_dst:    id_RegDst,
            alu_src:    id_ALUsrc,
            alu_ctr:    id_ALUctr,
            rs:         IF_ID_Rs,
            rt:         IF_ID_Rt,
            rd:         IF_ID_Rd
        };
        if (bubble_c) begin
            ctrl_d = '0;
        end
    end

    // Pipeline register; operands load every cycle, a bubble is marked by its zeroed control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            bus_a_q <= '0;
            bus_b_q <= '0;
            imm_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            bus_a_q <= id_busA;
            bus_b_q <= id_busB;
            imm_q   <= id_imm;
        end
    end

    assign ID_Ex_Rs       = ctrl_q.rs;
    assign ID_Ex_Rt       = ctrl_q.rt;
    assign ID_Ex_Rd       = ctrl_q.rd;
    assign ID_Ex_RegWr    = ctrl_q.reg_wr;
    assign ID_Ex_MemRead  = ctrl_q.mem_read;
    assign ID_Ex_MemWr    = ctrl_q.mem_wr;
    assign ID_Ex_MemtoReg = ctrl_q.mem_to_reg;
    assign ID_Ex_RegDst   = ctrl_q.reg_dst;
    assign ID_Ex_ALUsrc   = ctrl_q.alu_src;
    assign ID_Ex_ALUctr   = ctrl_q.alu_ctr;
    assign ID_Ex_busA     = bus_a_q;
    assign ID_Ex_busB     = bus_b_q;
    assign ID_Ex_imm      = imm_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: one instance with a single-bubble load stall, one with three.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic [4:0]  IF_ID_Rs, IF_ID_Rt, IF_ID_Rd;
    logic        id_uses_rt, id_RegWr, id_MemRead, id_MemWr, id_MemtoReg, id_RegDst, id_ALUsrc;
    logic [3:0]  id_ALUctr;
    logic [31:0] id_busA, id_busB, id_imm;
    logic        flush;

    logic [4:0]  d1_Rs, d1_Rt, d1_Rd, d3_Rs, d3_Rt, d3_Rd;
    logic        d1_RegWr, d1_MemRead, d1_MemWr, d1_MemtoReg, d1_RegDst, d1_ALUsrc;
    logic        d3_RegWr, d3_MemRead, d3_MemWr, d3_MemtoReg, d3_RegDst, d3_ALUsrc;
    logic [3:0]  d1_ALUctr, d3_ALUctr;
    logic [31:0] d1_busA, d1_busB, d1_imm, d3_busA, d3_busB, d3_imm;
    logic        d1_PC_Wr, d1_IF_ID_Wr, d1_stall, d3_PC_Wr, d3_IF_ID_Wr, d3_stall;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.DATA_W(32), .LOAD_STALL_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_Rd(IF_ID_Rd), .id_uses_rt(id_uses_rt),
        .id_RegWr(id_RegWr), .id_MemRead(id_MemRead), .id_MemWr(id_MemWr),
        .id_MemtoReg(id_MemtoReg), .id_RegDst(id_RegDst), .id_ALUsrc(id_ALUsrc),
        .id_ALUctr(id_ALUctr), .id_busA(id_busA), .id_busB(id_busB), .id_imm(id_imm),
        .flush(flush),
        .ID_Ex_Rs(d1_Rs), .ID_Ex_Rt(d1_Rt), .ID_Ex_Rd(d1_Rd),
        .ID_Ex_RegWr(d1_RegWr), .ID_Ex_MemRead(d1_MemRead), .ID_Ex_MemWr(d1_MemWr),
        .ID_Ex_MemtoReg(d1_MemtoReg), .ID_Ex_RegDst(d1_RegDst), .ID_Ex_ALUsrc(d1_ALUsrc),
        .ID_Ex_ALUctr(d1_ALUctr), .ID_Ex_busA(d1_busA), .ID_Ex_busB(d1_busB), .ID_Ex_imm(d1_imm),
        .PC_Wr(d1_PC_Wr), .IF_ID_Wr(d1_IF_ID_Wr), .stall_active(d1_stall)
    );

    id_ex_stage #(.DATA_W(32), .LOAD_STALL_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_Rd(IF_ID_Rd), .id_uses_rt(id_uses_rt),
        .id_RegWr(id_RegWr), .id_MemRead(id_MemRead), .id_MemWr(id_MemWr),
        .id_MemtoReg(id_MemtoReg), .id_RegDst(id_RegDst), .id_ALUsrc(id_ALUsrc),
        .id_ALUctr(id_ALUctr), .id_busA(id_busA), .id_busB(id_busB), .id_imm(id_imm),
        .flush(flush),
        .ID_Ex_Rs(d3_Rs), .ID_Ex_Rt(d3_Rt), .ID_Ex_Rd(d3_Rd),
        .ID_Ex_RegWr(d3_RegWr), .ID_Ex_MemRead(d3_MemRead), .ID_Ex_MemWr(d3_MemWr),
        .ID_Ex_MemtoReg(d3_MemtoReg), .ID_Ex_RegDst(d3_RegDst), .ID_Ex_ALUsrc(d3_ALUsrc),
        .ID_Ex_ALUctr(d3_ALUctr), .ID_Ex_busA(d3_busA), .ID_Ex_busB(d3_busB), .ID_Ex_imm(d3_imm),
        .PC_Wr(d3_PC_Wr), .IF_ID_Wr(d3_IF_ID_Wr), .stall_active(d3_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop_in();
        IF_ID_Rs = 5'd0; IF_ID_Rt = 5'd0; IF_ID_Rd = 5'd0; id_uses_rt = 1'b0;
        id_RegWr = 1'b0; id_MemRead = 1'b0; id_MemWr = 1'b0; id_MemtoReg = 1'b0;
        id_RegDst = 1'b0; id_ALUsrc = 1'b0; id_ALUctr = 4'd0;
        id_busA = 32'd0; id_busB = 32'd0; id_imm = 32'd0; flush = 1'b0;
    endtask

    task automatic lw_in(input logic [4:0] rt);
        nop_in();
        IF_ID_Rs = 5'd2; IF_ID_Rt = rt; id_RegWr = 1'b1; id_MemRead = 1'b1;
        id_MemtoReg = 1'b1; id_ALUsrc = 1'b1; id_busA = 32'h100; id_imm = 32'h4;
    endtask

    task automatic rtype_in(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic uses_rt);
        nop_in();
        IF_ID_Rs = rs; IF_ID_Rt = rt; IF_ID_Rd = rd; id_uses_rt = uses_rt;
        id_RegWr = 1'b1; id_RegDst = 1'b1; id_ALUctr = 4'd2;
        id_busA = 32'hA000_0000 + 32'(rs); id_busB = 32'hB000_0000 + 32'(rt);
    endtask

    task automatic settle();
        nop_in();
        repeat (4) tick();
    endtask

    initial begin
        // Reset holds every output at a bubble even with live inputs and a clock edge
        rst_n = 1'b0;
        rtype_in(5'd3, 5'd4, 5'd5, 1'b1);
        #2;
        check("rst_regwr", 32'(d1_RegWr), 32'd0);
        check("rst_pcwr", 32'(d1_PC_Wr), 32'd1);
        check("rst_ifidwr", 32'(d1_IF_ID_Wr), 32'd1);
        check("rst_stall", 32'(d1_stall), 32'd0);
        tick();
        check("rst_edge_rs", 32'(d1_Rs), 32'd0);
        check("rst_edge_busa", d1_busA, 32'd0);
        #2 rst_n = 1'b1;

        // Pass-through, one cycle latency
        nop_in();
        id_RegWr = 1'b1; IF_ID_Rs = 5'd3; id_busA = 32'h1234_5678;
        #1;
        check("pt_pcwr", 32'(d1_PC_Wr), 32'd1);
        check("pt_ifidwr", 32'(d1_IF_ID_Wr), 32'd1);
        tick();
        check("pt_regwr", 32'(d1_RegWr), 32'd1);
        check("pt_rs", 32'(d1_Rs), 32'd3);
        check("pt_busa", d1_busA, 32'h1234_5678);
        check("pt_pcwr_after", 32'(d1_PC_Wr), 32'd1);

        // Load-use on rs, single bubble
        lw_in(5'd8);
        #1 check("lu_no_stall_before", 32'(d1_stall), 32'd0);
        tick();
        check("lu_lw_memread", 32'(d1_MemRead), 32'd1);
        check("lu_lw_rt", 32'(d1_Rt), 32'd8);
        rtype_in(5'd8, 5'd5, 5'd10, 1'b1);
        #1;
        check("lu_pcwr", 32'(d1_PC_Wr), 32'd0);
        check("lu_ifidwr", 32'(d1_IF_ID_Wr), 32'd0);
        check("lu_stall", 32'(d1_stall), 32'd1);
        tick();
        check("lu_bub_regwr", 32'(d1_RegWr), 32'd0);
        check("lu_bub_memread", 32'(d1_MemRead), 32'd0);
        check("lu_bub_rd", 32'(d1_Rd), 32'd0);
        check("lu_bub_rt", 32'(d1_Rt), 32'd0);
        check("lu_stall_done", 32'(d1_stall), 32'd0);
        check("lu_pcwr_done", 32'(d1_PC_Wr), 32'd1);
        tick();
        check("lu_add_rd", 32'(d1_Rd), 32'd10);
        check("lu_add_rs", 32'(d1_Rs), 32'd8);
        check("lu_add_regwr", 32'(d1_RegWr), 32'd1);
        check("lu_add_aluctr", 32'(d1_ALUctr), 32'd2);
        settle();

        // Load into $0 never stalls
        lw_in(5'd0);
        tick();
        rtype_in(5'd0, 5'd0, 5'd11, 1'b1);
        #1 check("rt0_stall", 32'(d1_stall), 32'd0);
        tick();
        check("rt0_rd", 32'(d1_Rd), 32'd11);
        settle();

        // Matching rt without rt use (addi) does not stall
        lw_in(5'd9);
        tick();
        nop_in();
        IF_ID_Rs = 5'd1; IF_ID_Rt = 5'd9; id_RegWr = 1'b1; id_ALUsrc = 1'b1; id_uses_rt = 1'b0;
        #1 check("addi_stall", 32'(d1_stall), 32'd0);
        tick();
        check("addi_rt", 32'(d1_Rt), 32'd9);
        check("addi_regwr", 32'(d1_RegWr), 32'd1);
        settle();

        // Matching rt with rt use stalls
        lw_in(5'd9);
        tick();
        rtype_in(5'd1, 5'd9, 5'd13, 1'b1);
        #1 check("rtuse_stall", 32'(d1_stall), 32'd1);
        check("rtuse_pcwr", 32'(d1_PC_Wr), 32'd0);
        tick();
        check("rtuse_bub_regwr", 32'(d1_RegWr), 32'd0);
        tick();
        check("rtuse_rd", 32'(d1_Rd), 32'd13);
        settle();

        // Flush in RUN squashes a valid instruction
        rtype_in(5'd4, 5'd5, 5'd15, 1'b1);
        flush = 1'b1;
        #1 check("flrun_pcwr", 32'(d1_PC_Wr), 32'd1);
        tick();
        check("flrun_regwr", 32'(d1_RegWr), 32'd0);
        check("flrun_rd", 32'(d1_Rd), 32'd0);
        settle();

        // Three-cycle load stall
        lw_in(5'd8);
        tick();
        rtype_in(5'd8, 5'd6, 5'd12, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("ls3_stall%0d", i), 32'(d3_stall), 32'd1);
            check($sformatf("ls3_pcwr%0d", i), 32'(d3_PC_Wr), 32'd0);
            tick();
            check($sformatf("ls3_bub_regwr%0d", i), 32'(d3_RegWr), 32'd0);
            check($sformatf("ls3_bub_rd%0d", i), 32'(d3_Rd), 32'd0);
        end
        #1 check("ls3_stall_end", 32'(d3_stall), 32'd0);
        tick();
        check("ls3_add_rd", 32'(d3_Rd), 32'd12);
        check("ls3_add_regwr", 32'(d3_RegWr), 32'd1);
        settle();

        // Flush in the second stall cycle ends the stall
        lw_in(5'd8);
        tick();
        rtype_in(5'd8, 5'd6, 5'd14, 1'b1);
        #1 check("fl3_stall1", 32'(d3_stall), 32'd1);
        tick();
        flush = 1'b1;
        #1;
        check("fl3_stall", 32'(d3_stall), 32'd0);
        check("fl3_pcwr", 32'(d3_PC_Wr), 32'd1);
        check("fl3_ifidwr", 32'(d3_IF_ID_Wr), 32'd1);
        tick();
        flush = 1'b0;
        #1;
        check("fl3_bub_regwr", 32'(d3_RegWr), 32'd0);
        check("fl3_no_more_stall", 32'(d3_stall), 32'd0);
        check("fl3_pcwr_after", 32'(d3_PC_Wr), 32'd1);
        tick();
        check("fl3_add_rd", 32'(d3_Rd), 32'd14);
        settle();

        // Asynchronous reset in the second stall cycle
        lw_in(5'd8);
        tick();
        rtype_in(5'd8, 5'd6, 5'd16, 1'b1);
        tick();
        #1 check("rs3_stall_pre", 32'(d3_stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rs3_stall", 32'(d3_stall), 32'd0);
        check("rs3_pcwr", 32'(d3_PC_Wr), 32'd1);
        check("rs3_regwr", 32'(d3_RegWr), 32'd0);
        check("rs3_busa", d3_busA, 32'd0);
        check("rs3_busb", d3_busB, 32'd0);
        check("rs3_d1_busa", d1_busA, 32'd0);
        tick();
        #2 rst_n = 1'b1;
        nop_in();
        id_RegWr = 1'b1; IF_ID_Rs = 5'd7; id_busA = 32'hCAFE_0001;
        #1 check("rs3_post_stall", 32'(d3_stall), 32'd0);
        tick();
        check("rs3_post_regwr", 32'(d3_RegWr), 32'd1);
        check("rs3_post_rs", 32'(d3_Rs), 32'd7);
        check("rs3_post_busa", d3_busA, 32'hCAFE_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
